cpu_data_path: RTL and testbench

//  32-bit single-bus CPU datapath: register file R0-R15, HI, LO, PC, MDR, Y, in-port reg and 64-bit Z.
//  A one-hot "out" vector drives one source onto the shared bus; "in" strobes capture on the Clock rising edge.
//  The ALU computes Y (A) op BusOut (B) combinationally; the result lands in Z.

---
 rtl/cpu_dp_pkg.sv | 21 ++
 rtl/cpu_alu.sv | 60 ++++++
 rtl/cpu_data_path.sv | 118 +++++++++++
 tb/tb_cpu_data_path.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dp_pkg.sv
// Shared constants for the single-bus CPU datapath: word widths, source count and ALU opcodes.
package cpu_dp_pkg;
  localparam int WORD_W   = 32;
  localparam int DWORD_W  = 64;
  localparam int NUM_REGS = 16;
  localparam int NUM_SRC  = 24;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result = A op B, 64 bits wide.
// Signed MUL/DIV exist only when DATA_PATH_MULDIV_EN is defined; otherwise those opcodes yield 0.
module cpu_alu
  import cpu_dp_pkg::*;
(
  input  logic [WORD_W-1:0]  a_i,
  input  logic [WORD_W-1:0]  b_i,
  input  logic [4:0]         op_i,
  output logic [DWORD_W-1:0] result_o
);

  logic [4:0]         amt_s;
  logic [DWORD_W-1:0] ror_s;
  logic [DWORD_W-1:0] rol_s;

  assign amt_s = b_i[4:0];
  // Rotating a doubled word keeps amount 0 a clean pass-through.
  assign ror_s = {a_i, a_i} >> amt_s;
  assign rol_s = {a_i, a_i} << amt_s;

`ifdef DATA_PATH_MULDIV_EN
  logic signed [DWORD_W-1:0] mul_a_s;
  logic signed [DWORD_W-1:0] mul_b_s;
  logic signed [DWORD_W-1:0] mul_s;
  logic signed [WORD_W-1:0]  quo_s;
  logic signed [WORD_W-1:0]  rem_s;

  assign mul_a_s = {{WORD_W{a_i[WORD_W-1]}}, a_i};
  assign mul_b_s = {{WORD_W{b_i[WORD_W-1]}}, b_i};
  assign mul_s   = mul_a_s * mul_b_s;
  assign quo_s   = (b_i == 32'h0) ? 32'sh0 : ($signed(a_i) / $signed(b_i));
  assign rem_s   = (b_i == 32'h0) ? 32'sh0 : ($signed(a_i) % $signed(b_i));
`endif

  always_comb begin
    result_o = {DWORD_W{1'b0}};
    case (op_i)
      OP_ADD:  result_o = {32'h0, a_i + b_i};
      OP_SUB:  result_o = {32'h0, a_i - b_i};
      OP_AND:  result_o = {32'h0, a_i & b_i};
      OP_OR:   result_o = {32'h0, a_i | b_i};
      OP_SHR:  result_o = {32'h0, a_i >> amt_s};
      OP_SHRA: result_o = {32'h0, $signed(a_i) >>> amt_s};
      OP_SHL:  result_o = {32'h0, a_i << amt_s};
      OP_ROR:  result_o = {32'h0, ror_s[31:0]};
      OP_ROL:  result_o = {32'h0, rol_s[63:32]};
`ifdef DATA_PATH_MULDIV_EN
      OP_MUL:  result_o = mul_s;
      OP_DIV:  result_o = {rem_s, quo_s};
`else
      OP_MUL:  result_o = {DWORD_W{1'b0}};
      OP_DIV:  result_o = {DWORD_W{1'b0}};
`endif
      OP_NEG:  result_o = {32'h0, 32'h0 - b_i};
      OP_NOT:  result_o = {32'h0, ~b_i};
      default: result_o = {DWORD_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/cpu_data_path.sv
// Single-bus CPU datapath: register file, special registers, priority bus mux and 64-bit Z.
// Optional signed MUL/DIV in the ALU is enabled by defining DATA_PATH_MULDIV_EN.
module cpu_data_path
  import cpu_dp_pkg::*;
(
  input  logic              Clock,
  input  logic              clear,
  input  logic              Read,
  input  logic [4:0]        op,
  input  logic [WORD_W-1:0] Mdatain,
  input  logic R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic HIOut,  input logic LOout,  input logic Zhighout, input logic Zlowout,
  input  logic PCout,  input logic MDRout, input logic InPortout, input logic Yout,
  input  logic R0in,   input logic R1in,   input logic R2in,   input logic R3in,
  input  logic R4in,   input logic R5in,   input logic R6in,   input logic R7in,
  input  logic R8in,   input logic R9in,   input logic R10in,  input logic R11in,
  input  logic R12in,  input logic R13in,  input logic R14in,  input logic R15in,
  input  logic HIin,   input logic Loin,   input logic InPC,   input logic InPortin,
  input  logic Yin,    input logic ZHighin, input logic Zlowin, input logic MDRin,
  output logic [WORD_W-1:0] BusOut,
  output logic [WORD_W-1:0] mdrData,
  output logic [WORD_W-1:0] BusMuxInR0,
  output logic [WORD_W-1:0] BusMuxInR1,
  output logic [WORD_W-1:0] BusMuxInR2,
  output logic [WORD_W-1:0] BusMuxInYOut
);

  logic [WORD_W-1:0]   rf_q [NUM_REGS];
  logic [WORD_W-1:0]   rf_d [NUM_REGS];
  logic [WORD_W-1:0]   hi_q, hi_d, lo_q, lo_d, pc_q, pc_d;
  logic [WORD_W-1:0]   mdr_q, mdr_d, y_q, y_d, inport_q, inport_d;
  logic [DWORD_W-1:0]  z_q, z_d;
  logic [DWORD_W-1:0]  alu_s;
  logic [NUM_REGS-1:0] r_in_s;
  logic [NUM_SRC-1:0]  sel_s;
  logic [WORD_W-1:0]   src_s [NUM_SRC];
  logic [WORD_W-1:0]   bus_s;

  assign r_in_s = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  // Bit index doubles as priority rank: bit 0 (R0out) wins over everything above it.
  assign sel_s  = {Yout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIOut,
                   R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  // Gather all bus sources in priority-rank order.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) src_s[i] = rf_q[i];
    src_s[16] = hi_q;
    src_s[17] = lo_q;
    src_s[18] = z_q[63:32];
    src_s[19] = z_q[31:0];
    src_s[20] = pc_q;
    src_s[21] = mdr_q;
    src_s[22] = inport_q;
    src_s[23] = y_q;
  end

  // Priority bus mux: scan from lowest to highest priority so the last hit wins.
  always_comb begin
    bus_s = {WORD_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) bus_s = sel_s[i] ? src_s[i] : bus_s;
  end

  cpu_alu u_alu (
    .a_i      (y_q),
    .b_i      (bus_s),
    .op_i     (op),
    .result_o (alu_s)
  );

  // Next-state for every register: load on strobe, otherwise hold.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) rf_d[i] = r_in_s[i] ? bus_s : rf_q[i];
    hi_d     = HIin     ? bus_s : hi_q;
    lo_d     = Loin     ? bus_s : lo_q;
    pc_d     = InPC     ? bus_s : pc_q;
    inport_d = InPortin ? bus_s : inport_q;
    y_d      = Yin      ? bus_s : y_q;
    mdr_d    = MDRin    ? (Read ? Mdatain : bus_s) : mdr_q;
    z_d      = {ZHighin ? alu_s[63:32] : z_q[63:32],
                Zlowin  ? alu_s[31:0]  : z_q[31:0]};
  end

  // State registers with asynchronous clear.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= {WORD_W{1'b0}};
      hi_q     <= {WORD_W{1'b0}};
      lo_q     <= {WORD_W{1'b0}};
      pc_q     <= {WORD_W{1'b0}};
      inport_q <= {WORD_W{1'b0}};
      y_q      <= {WORD_W{1'b0}};
      mdr_q    <= {WORD_W{1'b0}};
      z_q      <= {DWORD_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= rf_d[i];
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pc_q     <= pc_d;
      inport_q <= inport_d;
      y_q      <= y_d;
      mdr_q    <= mdr_d;
      z_q      <= z_d;
    end
  end

  assign BusOut       = bus_s;
  assign mdrData      = mdr_q;
  assign BusMuxInR0   = rf_q[0];
  assign BusMuxInR1   = rf_q[1];
  assign BusMuxInR2   = rf_q[2];
  assign BusMuxInYOut = y_q;

endmodule

// File: tb/tb_cpu_data_path.sv
// Directed self-checking bench for cpu_data_path; expectations follow DATA_PATH_MULDIV_EN.
module tb_cpu_data_path;
  logic        Clock = 1'b0;
  logic        clear, Read;
  logic [4:0]  op;
  logic [31:0] Mdatain;
  logic [15:0] r_out, r_in;
  logic HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout;
  logic HIin, Loin, InPC, InPortin, Yin, ZHighin, Zlowin, MDRin;
  logic [31:0] BusOut, mdrData, BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInYOut;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  cpu_data_path dut (
    .Clock(Clock), .clear(clear), .Read(Read), .op(op), .Mdatain(Mdatain),
    .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
    .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
    .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .HIOut(HIOut), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Yout(Yout),
    .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
    .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
    .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .HIin(HIin), .Loin(Loin), .InPC(InPC), .InPortin(InPortin),
    .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin), .MDRin(MDRin),
    .BusOut(BusOut), .mdrData(mdrData), .BusMuxInR0(BusMuxInR0),
    .BusMuxInR1(BusMuxInR1), .BusMuxInR2(BusMuxInR2), .BusMuxInYOut(BusMuxInYOut)
  );

  task automatic idle();
    Read = 1'b0; op = 5'b00000; Mdatain = 32'h0;
    r_out = 16'h0; r_in = 16'h0;
    HIOut = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    PCout = 1'b0; MDRout = 1'b0; InPortout = 1'b0; Yout = 1'b0;
    HIin = 1'b0; Loin = 1'b0; InPC = 1'b0; InPortin = 1'b0;
    Yin = 1'b0; ZHighin = 1'b0; Zlowin = 1'b0; MDRin = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic mdr_load(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
    idle();
  endtask

  task automatic load_y(input logic [31:0] v);
    mdr_load(v);
    MDRout = 1'b1; Yin = 1'b1;
    tick();
    idle();
  endtask

  task automatic load_r(input int idx, input logic [31:0] v);
    mdr_load(v);
    MDRout = 1'b1; r_in[idx] = 1'b1;
    tick();
    idle();
  endtask

  task automatic run_alu(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] z);
    load_y(a);
    load_r(3, b);
    op = opc; r_out[3] = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1;
    tick();
    idle();
    Zlowout = 1'b1; #1; z[31:0] = BusOut; Zlowout = 1'b0;
    Zhighout = 1'b1; #1; z[63:32] = BusOut; Zhighout = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] got [6];
    load_r(0, 32'h1111_1111);
    load_r(1, 32'h2222_2222);
    load_r(2, 32'h3333_3333);
    load_y(32'h4444_4444);
    #2; clear = 1'b1; #1;
    got = '{BusOut, mdrData, BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInYOut};
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (got[i] !== 32'h0) begin
        fails++;
        $display("FAIL reset_out%0d: got %h expected 00000000", i, got[i]);
      end
    end
    clear = 1'b0;
    Yout = 1'b1; #1;
    tests++;
    if (BusOut !== 32'h0) begin
      fails++; $display("FAIL reset_y_bus: got %h expected 00000000", BusOut);
    end
    idle(); #1;
  endtask

  task automatic test_ror();
    mdr_load(32'hFFFF_FFF4);
    MDRout = 1'b1; Yin = 1'b1; tick(); idle();
    mdr_load(32'h0000_0005);
    MDRout = 1'b1; r_in[2] = 1'b1; tick(); idle();
    op = 5'b00111; r_out[2] = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; tick(); idle();
    Zlowout = 1'b1; r_in[1] = 1'b1; tick(); idle();
    Zhighout = 1'b1; r_in[0] = 1'b1; tick(); idle();
    tests++;
    if (BusMuxInYOut !== 32'hFFFF_FFF4) begin
      fails++; $display("FAIL ror_y: got %h expected fffffff4", BusMuxInYOut);
    end
    tests++;
    if (BusMuxInR2 !== 32'h5) begin
      fails++; $display("FAIL ror_r2: got %h expected 00000005", BusMuxInR2);
    end
    tests++;
    if (BusMuxInR1 !== 32'hA7FF_FFFF) begin
      fails++; $display("FAIL ror_r1: got %h expected a7ffffff", BusMuxInR1);
    end
    tests++;
    if (BusMuxInR0 !== 32'h0) begin
      fails++; $display("FAIL ror_r0: got %h expected 00000000", BusMuxInR0);
    end
    tests++;
    if (mdrData !== 32'h5) begin
      fails++; $display("FAIL ror_mdr: got %h expected 00000005", mdrData);
    end
  endtask

  task automatic test_add();
    load_y(32'd7);
    load_r(3, 32'd9);
    op = 5'b00000; r_out[3] = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; tick(); idle();
    Zlowout = 1'b1; #1;
    tests++;
    if (BusOut !== 32'd16) begin
      fails++; $display("FAIL add_zlow: got %h expected 00000010", BusOut);
    end
    idle(); #1;
  endtask

  task automatic test_bus_priority();
    load_r(1, 32'hCAFE_0001);
    load_y(32'hBEEF_0002);
    r_out[1] = 1'b1; Yout = 1'b1; #1;
    tests++;
    if (BusOut !== 32'hCAFE_0001) begin
      fails++; $display("FAIL prio_r1_y: got %h expected cafe0001", BusOut);
    end
    idle(); MDRout = 1'b1; Yout = 1'b1; #1;
    tests++;
    if (BusOut !== 32'hBEEF_0002) begin
      fails++; $display("FAIL prio_mdr_y: got %h expected beef0002", BusOut);
    end
    idle(); #1;
    tests++;
    if (BusOut !== 32'h0) begin
      fails++; $display("FAIL prio_none: got %h expected 00000000", BusOut);
    end
  endtask

  task automatic test_multi_load();
    load_r(4, 32'h1234_5678);
    r_out[4] = 1'b1; r_in[5] = 1'b1; HIin = 1'b1; Loin = 1'b1; InPC = 1'b1; InPortin = 1'b1;
    tick(); idle();
    Read = 1'b0; r_out[5] = 1'b1; MDRin = 1'b1; tick(); idle();
    HIOut = 1'b1; #1;
    tests++;
    if (BusOut !== 32'h1234_5678) begin
      fails++; $display("FAIL multi_hi: got %h expected 12345678", BusOut);
    end
    idle(); LOout = 1'b1; #1;
    tests++;
    if (BusOut !== 32'h1234_5678) begin
      fails++; $display("FAIL multi_lo: got %h expected 12345678", BusOut);
    end
    idle(); PCout = 1'b1; #1;
    tests++;
    if (BusOut !== 32'h1234_5678) begin
      fails++; $display("FAIL multi_pc: got %h expected 12345678", BusOut);
    end
    idle(); InPortout = 1'b1; #1;
    tests++;
    if (BusOut !== 32'h1234_5678) begin
      fails++; $display("FAIL multi_inport: got %h expected 12345678", BusOut);
    end
    idle(); #1;
    tests++;
    if (mdrData !== 32'h1234_5678) begin
      fails++; $display("FAIL mdr_from_bus: got %h expected 12345678", mdrData);
    end
    tick();
    tests++;
    if (mdrData !== 32'h1234_5678) begin
      fails++; $display("FAIL mdr_hold: got %h expected 12345678", mdrData);
    end
  endtask

  task automatic test_alu_ops();
    logic [4:0]  ops [13];
    logic [31:0] as  [13];
    logic [31:0] bs  [13];
    logic [63:0] exp [13];
    logic [63:0] z;
    ops = '{5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01000,
            5'b00111, 5'b01011, 5'b01100, 5'b11111, 5'b01001, 5'b01010};
    as  = '{32'd5, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h8000_0000, 32'h8000_0000,
            32'h0000_0001, 32'h8000_0001, 32'h1234_5678, 32'h0, 32'h0,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd17};
    bs  = '{32'd9, 32'hFF00_FF00, 32'hFF00_FF00, 32'd4, 32'd4, 32'd31, 32'd1,
            32'h20, 32'd1, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h10, 32'd5};
    exp = '{64'hFFFF_FFFC, 64'hF000_F000, 64'hFFF0_FFF0, 64'h0800_0000, 64'hF800_0000,
            64'h8000_0000, 64'h0000_0003, 64'h1234_5678, 64'hFFFF_FFFF, 64'hF0F0_F0F0,
            64'h0,
`ifdef DATA_PATH_MULDIV_EN
            64'hFFFF_FFFF_FFFF_FFD0, 64'h0000_0002_0000_0003};
`else
            64'h0, 64'h0};
`endif
    for (int i = 0; i < 13; i++) begin
      run_alu(ops[i], as[i], bs[i], z);
      tests++;
      if (z !== exp[i]) begin
        fails++;
        $display("FAIL alu_op%05b: got %h expected %h", ops[i], z, exp[i]);
      end
    end
  endtask

  initial begin
    idle();
    clear = 1'b1;
    #12;
    tests++;
    if (BusMuxInR0 !== 32'h0 || BusMuxInYOut !== 32'h0 || mdrData !== 32'h0) begin
      fails++; $display("FAIL power_on: got r0 %h y %h mdr %h expected 0", BusMuxInR0, BusMuxInYOut, mdrData);
    end
    clear = 1'b0;
    tick();
    test_reset();
    test_ror();
    test_add();
    test_bus_priority();
    test_multi_load();
    test_alu_ops();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
